// File: rtl/network_div_pkg.sv
// Shared types and constants for the iterative signed divider.
// Holds the FSM state enum, default widths and saturation limits.
package network_div_pkg;

    localparam int DEF_DIVIDEND_W = 28;
    localparam int DEF_DIVISOR_W  = 12;
    localparam int DEF_QUOT_W     = 16;

    // Saturation limits of the signed quotient at the default width.
    localparam int QMAX = (1 << (DEF_QUOT_W - 1)) - 1;
    localparam int QMIN = -(1 << (DEF_QUOT_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/network_div_step.sv
// One combinational restoring-division step.
// Ports: prem (partial remainder), din (next dividend bit), dmag (|divisor|),
//        prem_nxt (updated remainder), qbit (quotient bit).
module network_div_step
    import network_div_pkg::*;
#(
    parameter int DW = DEF_DIVISOR_W
) (
    input  logic [DW-1:0] prem,
    input  logic          din,
    input  logic [DW-1:0] dmag,
    output logic [DW-1:0] prem_nxt,
    output logic          qbit
);

    logic [DW:0] sh;

    // prem < dmag always holds, so the restored value fits back in DW bits.
    always_comb begin
        sh       = {prem, din};
        qbit     = (sh >= {1'b0, dmag});
        prem_nxt = qbit ? DW'(sh - {1'b0, dmag}) : DW'(sh);
    end

endmodule

// File: rtl/network_div_28s_12s_16_seq.sv
// Iterative signed divider: 28s / 12s -> 16s saturating quotient, one bit per ce.
// Ports: clk, reset_n (sync, active-low), ce, in_valid/in_ready, dividend, divisor,
//        out_valid/out_ready, quot, rem, sat, dbz.
module network_div_28s_12s_16_seq
    import network_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [QUOT_W-1:0]     quot,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                         sat,
    output logic                         dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(QMAX);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(-QMIN);

    state_t state, nxt;

    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] nmag;
    logic [DIVIDEND_W-1:0] qmag;
    logic [DIVISOR_W-1:0]  dmag;
    logic [DIVISOR_W-1:0]  prem;
    logic                  sn;
    logic                  sd;

    logic [DIVIDEND_W-1:0] nabs;
    logic [DIVISOR_W-1:0]  dabs;
    logic [DIVISOR_W-1:0]  prem_nxt;
    logic                  qbit;
    logic                  neg_q;
    logic                  q_ovf;
    logic [QUOT_W-1:0]     q_fix;
    logic [DIVISOR_W-1:0]  r_fix;

    network_div_step #(
        .DW(DIVISOR_W)
    ) u_step (
        .prem    (prem),
        .din     (nmag[DIVIDEND_W-1]),
        .dmag    (dmag),
        .prem_nxt(prem_nxt),
        .qbit    (qbit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Magnitudes; the most negative operands map to 2^(W-1), which fits unsigned.
    always_comb begin
        nabs = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-dividend) : DIVIDEND_W'(dividend);
        dabs = divisor[DIVISOR_W-1] ? DIVISOR_W'(-divisor) : DIVISOR_W'(divisor);
    end

    // Sign fix-up and clamp; negative side allows one more magnitude step.
    always_comb begin
        neg_q = sn ^ sd;
        q_ovf = neg_q ? (qmag > NEG_LIM) : (qmag > POS_LIM);
        q_fix = neg_q ? QUOT_W'(-qmag[QUOT_W-1:0]) : qmag[QUOT_W-1:0];
        r_fix = sn ? DIVISOR_W'(-prem) : prem;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (in_valid) nxt = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt == '0) nxt = FIX;
            FIX:  nxt = DONE;
            DONE: if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            nmag <= '0;
            qmag <= '0;
            dmag <= '0;
            prem <= '0;
            sn   <= 1'b0;
            sd   <= 1'b0;
            quot <= '0;
            rem  <= '0;
            sat  <= 1'b0;
            dbz  <= 1'b0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sn   <= dividend[DIVIDEND_W-1];
                        sd   <= divisor[DIVISOR_W-1];
                        nmag <= nabs;
                        dmag <= dabs;
                        qmag <= '0;
                        prem <= '0;
                        cnt  <= CNT_W'(DIVIDEND_W - 1);
                    end
                end
                CALC: begin
                    prem <= prem_nxt;
                    qmag <= {qmag[DIVIDEND_W-2:0], qbit};
                    nmag <= {nmag[DIVIDEND_W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    if (dmag == '0) begin
                        quot <= sn ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
                        rem  <= '0;
                        sat  <= 1'b0;
                        dbz  <= 1'b1;
                    end else begin
                        if (q_ovf) begin
                            quot <= neg_q ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
                        end else begin
                            quot <= q_fix;
                        end
                        rem <= r_fix;
                        sat <= q_ovf;
                        dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_network_div_28s_12s_16_seq.sv
// Scoreboard bench for the iterative signed divider.
// Directed cases, backpressure, ce stall, mid-op reset, then random operands.
module tb_network_div_28s_12s_16_seq;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               ce = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [27:0] dividend = '0;
    logic signed [11:0] divisor = '0;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] quot;
    logic signed [11:0] rem;
    logic               sat;
    logic               dbz;

    network_div_28s_12s_16_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .sat      (sat),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint q;
        longint r;
        longint s;
        longint z;
        int     lat;
        int     acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division truncates toward zero and the
    // remainder follows the dividend sign; then clamp to 16-bit signed.
    function automatic exp_t model(input longint a, input longint b);
        exp_t e;
        longint qq;
        e.lat = 0;
        e.acc = 0;
        if (b == 0) begin
            e.q = (a < 0) ? -32768 : 32767;
            e.r = 0;
            e.s = 0;
            e.z = 1;
        end else begin
            qq = a / b;
            e.r = a % b;
            e.z = 0;
            e.s = 0;
            e.q = qq;
            if (qq > 32767) begin
                e.q = 32767;
                e.s = 1;
            end else if (qq < -32768) begin
                e.q = -32768;
                e.s = 1;
            end
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'b0;
        else out_ready = ($urandom % 4) != 0;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid) begin
                if (sb.size() == 0) begin
                    chk("stale_valid", 1, 0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        chk("latency", longint'(cyc - e.acc + 1), longint'(e.lat));
                        seen = 1;
                    end
                    chk("quot", longint'(quot), e.q);
                    chk("rem", longint'(rem), e.r);
                    chk("sat", longint'(sat), e.s);
                    chk("dbz", longint'(dbz), e.z);
                    chk("in_ready_busy", longint'(in_ready), 0);
                    if (out_ready && ce) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_quot", longint'(quot), 0);
        chk("rst_rem", longint'(rem), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_dbz", longint'(dbz), 0);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input logic signed [27:0] a, input logic signed [11:0] b,
                         input int stall, input bit push);
        exp_t e;
        bit ok;
        e = model(longint'(a), longint'(b));
        e.lat = ((b == 0) ? 2 : 30) + stall;
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready && ce) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        e.acc = cyc + 1;
        if (push && ok) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 28'($urandom);
        if (stall > 0) begin
            repeat (5) @(posedge clk);
            #1 ce = 1'b0;
            repeat (stall) @(posedge clk);
            #1 ce = 1'b1;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", longint'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        logic [31:0] r;
        logic [31:0] rb;
        logic signed [27:0] a;
        logic signed [11:0] b;
        int m;
        int bs;
        bit ok;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(28'sd1000, 12'sd7, 0, 1);
        issue(-28'sd1000, 12'sd7, 0, 1);
        issue(28'sd1000, -12'sd7, 0, 1);
        issue(-28'sd134217728, -12'sd1, 0, 1);
        issue(28'sd134217727, 12'sd1, 0, 1);
        issue(-28'sd65536, 12'sd2, 0, 1);
        issue(-28'sd134217728, -12'sd2048, 0, 1);
        issue(28'sd5, 12'sd0, 0, 1);
        issue(-28'sd5, 12'sd0, 0, 1);
        issue(28'sd0, -12'sd9, 0, 1);
        drain();

        rdy_mode = 1;
        issue(28'sd77777, -12'sd13, 0, 1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("bp_valid_timeout", 0, 1);
        repeat (10) @(posedge clk);
        #1 rdy_mode = 0;
        drain();

        issue(28'sd123456, -12'sd45, 5, 1);
        drain();

        issue(28'sd5000000, 12'sd77, 0, 0);
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals();
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        issue(28'sd100, 12'sd3, 0, 1);
        drain();

        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            rb = $urandom;
            m = $urandom_range(0, 2);
            bs = $urandom_range(0, 9);
            if (m == 0) a = r[27:0];
            else if (m == 1) a = {{8{r[19]}}, r[19:0]};
            else a = {{16{r[11]}}, r[11:0]};
            if (bs == 0) b = '0;
            else if (bs < 5) b = rb[11:0];
            else b = {{8{rb[3]}}, rb[3:0]};
            issue(a, b, 0, 1);
        end
        drain();
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
